// File: rtl/sig_gen.sv
// Programmable square/PWM generator: converts a frequency (Hz) and a duty (%) into cycle counts
// with a shared sequential restoring divider, then commits them glitch-free at a period boundary.
module sig_gen #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned FREQ_W = 28,
  parameter int unsigned DUTY_W = 7
) (
  input  logic              clk_100M,
  input  logic              rst,
  input  logic              load,
  input  logic [FREQ_W-1:0] freq_set,
  input  logic [DUTY_W-1:0] duty_set,
  output logic              busy,
  output logic              sign_out,
  output logic [31:0]       period_out
);

  typedef enum logic [2:0] {StIdle, StDivP, StMul, StDivH, StPend} state_e;

  localparam logic [31:0]       ClkHz   = 32'(CLK_HZ);
  localparam logic [DUTY_W-1:0] DutyMax = DUTY_W'(100);

  state_e            state_q, state_d;
  logic [5:0]        step_q, step_d;
  // Dividend shift register; quotient bits enter at the LSB as dividend bits leave the MSB.
  logic [39:0]       dvd_q, dvd_d;
  logic [32:0]       rem_q, rem_d;
  logic [31:0]       dsr_q, dsr_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [31:0]       p_q, p_d;
  logic [31:0]       period_q, period_d;
  logic [31:0]       high_q, high_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              sign_q, sign_d;

  logic [33:0]       trial;
  logic [33:0]       diff;
  logic              trial_ge;
  logic [32:0]       rem_iter;
  logic [39:0]       dvd_iter;
  logic [31:0]       p_div;
  logic [31:0]       p_clamp;
  logic [38:0]       prod;
  logic [DUTY_W-1:0] duty_clamp;
  logic              at_boundary;
  logic              commit;

  // One restoring-division step.
  always_comb begin
    trial    = {rem_q, dvd_q[39]};
    diff     = trial - {2'b00, dsr_q};
    trial_ge = (trial >= {2'b00, dsr_q});
    rem_iter = trial_ge ? diff[32:0] : trial[32:0];
    dvd_iter = {dvd_q[38:0], trial_ge};
  end

  always_comb begin
    p_div      = dvd_q[31:0];
    p_clamp    = (p_div < 32'd2) ? 32'd2 : p_div;
    prod       = 39'(p_clamp) * 39'(duty_q);
    duty_clamp = (duty_set > DutyMax) ? DutyMax : duty_set;
  end

  assign at_boundary = (period_q == 32'd0) || (cnt_q == period_q - 32'd1);

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    duty_d   = duty_q;
    p_d      = p_q;
    period_d = period_q;
    high_d   = high_q;
    commit   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          duty_d = duty_clamp;
          rem_d  = '0;
          step_d = '0;
          if (freq_set == '0) begin
            p_d     = '0;
            dvd_d   = '0;
            state_d = StPend;
          end else begin
            dvd_d   = {ClkHz, 8'd0};
            dsr_d   = 32'(freq_set);
            state_d = StDivP;
          end
        end
      end
      StDivP: begin
        dvd_d  = dvd_iter;
        rem_d  = rem_iter;
        step_d = step_q + 6'd1;
        if (step_q == 6'd31) state_d = StMul;
      end
      StMul: begin
        p_d     = p_clamp;
        dvd_d   = {1'b0, prod};
        rem_d   = '0;
        dsr_d   = 32'd100;
        step_d  = '0;
        state_d = StDivH;
      end
      StDivH: begin
        if (step_q == 6'd40) begin
          state_d = StPend;
        end else begin
          dvd_d  = dvd_iter;
          rem_d  = rem_iter;
          step_d = step_q + 6'd1;
        end
      end
      StPend: begin
        // The high count is the DIVH quotient, or zero when stopping.
        if (at_boundary) begin
          commit   = 1'b1;
          period_d = p_q;
          high_d   = dvd_q[31:0];
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d  = '0;
    sign_d = 1'b0;
    if (period_q != 32'd0) begin
      cnt_d  = (cnt_q == period_q - 32'd1) ? 32'd0 : cnt_q + 32'd1;
      sign_d = (cnt_q < high_q);
    end
    if (commit) cnt_d = '0;
  end

  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      step_q   <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      duty_q   <= '0;
      p_q      <= '0;
      period_q <= '0;
      high_q   <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      duty_q   <= duty_d;
      p_q      <= p_d;
      period_q <= period_d;
      high_q   <= high_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign sign_out   = sign_q;
  assign period_out = period_q;

endmodule

// File: tb/tb_sig_gen.sv
// Bench for sig_gen: table of load requests with hand-derived period/high counts, a scoreboard of
// expected commits, cycle-exact waveform checks around each retune, and an async-reset abort.
module tb_sig_gen;

  logic        clk_100M = 1'b0;
  logic        rst      = 1'b0;
  logic        load     = 1'b0;
  logic [27:0] freq_set = '0;
  logic [6:0]  duty_set = '0;
  logic        busy;
  logic        sign_out;
  logic [31:0] period_out;

  sig_gen dut (
    .clk_100M  (clk_100M),
    .rst       (rst),
    .load      (load),
    .freq_set  (freq_set),
    .duty_set  (duty_set),
    .busy      (busy),
    .sign_out  (sign_out),
    .period_out(period_out)
  );

  always #5 clk_100M = ~clk_100M;

  typedef struct {
    int unsigned freq;
    int unsigned duty;
    int unsigned pre;    // idle cycles before the load, counted from a cnt=0 point
    bit          poke;   // fire an extra load while busy; it must be ignored
    int unsigned exp_p;
    int unsigned exp_h;
  } vec_t;

  typedef struct {
    int unsigned p;
    int unsigned h;
    int unsigned k;      // expected busy length in cycles
  } exp_t;

  vec_t        vecs[12];
  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cur_p = 0;
  int unsigned cur_h = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100M);
    #1;
  endtask

  function automatic int unsigned busy_len(int unsigned c0, int unsigned freq);
    int unsigned k;
    k = (freq == 0) ? 1 : 75;
    if (cur_p != 0) begin
      while (((c0 + k) % cur_p) != cur_p - 1) k++;
    end
    return k;
  endfunction

  // Drives one request, checks the old waveform and busy length, then the committed result.
  task automatic run_vec(input vec_t v, input int idx);
    exp_t        e;
    int unsigned c0;
    int unsigned j;
    int unsigned bad;
    int unsigned n;
    bit          exp_sig;
    for (int i = 0; i < int'(v.pre); i++) tick();
    c0 = (cur_p == 0) ? 0 : v.pre % cur_p;
    e.p = v.exp_p;
    e.h = v.exp_h;
    e.k = busy_len(c0, v.freq);
    sb.push_back(e);
    freq_set = 28'(v.freq);
    duty_set = 7'(v.duty);
    load     = 1'b1;
    tick();
    load = 1'b0;
    j    = 0;
    bad  = 0;
    while (j <= 3000) begin
      exp_sig = (cur_p == 0) ? 1'b0 : (((c0 + j) % cur_p) < cur_h);
      if (sign_out !== exp_sig) bad++;
      if (!busy) break;
      load = 1'b0;
      if (v.poke && j == 5) begin
        freq_set = 28'd1_000_000;
        duty_set = 7'd50;
        load     = 1'b1;
      end
      tick();
      j++;
    end
    load = 1'b0;
    if (busy) begin
      check($sformatf("v%0d busy_timeout", idx), 1, 0);
      return;
    end
    e = sb.pop_front();
    check($sformatf("v%0d busy_len", idx), j, e.k);
    check($sformatf("v%0d old_wave_errs", idx), bad, 0);
    check($sformatf("v%0d period_out", idx), period_out, e.p);
    bad = 0;
    n   = (e.p == 0) ? 20 : 2 * e.p;
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      exp_sig = (e.p == 0) ? 1'b0 : ((i % e.p) < e.h);
      if (sign_out !== exp_sig) bad++;
    end
    check($sformatf("v%0d new_wave_errs", idx), bad, 0);
    cur_p = e.p;
    cur_h = e.h;
  endtask

  initial begin
    int unsigned bad;
    vec_t        v;
    vecs[0]  = '{1_000_000,  50,  0, 1'b0, 100,  50};
    vecs[1]  = '{2_500_000,  25, 30, 1'b0,  40,  10};
    vecs[2]  = '{60_000_000, 50,  0, 1'b0,   2,   1};
    vecs[3]  = '{30_000_000, 33,  1, 1'b0,   3,   0};
    vecs[4]  = '{1_000_000,   0,  0, 1'b0, 100,   0};
    vecs[5]  = '{1_000_000, 100,  7, 1'b0, 100, 100};
    vecs[6]  = '{1_000_000, 120,  0, 1'b0, 100, 100};
    vecs[7]  = '{1_000_000,   1, 55, 1'b0, 100,   1};
    vecs[8]  = '{7_000_000,  37,  0, 1'b0,  14,   5};
    vecs[9]  = '{0,          50,  3, 1'b1,   0,   0};
    vecs[10] = '{0,           0,  0, 1'b0,   0,   0};
    vecs[11] = '{33_333_333, 50,  0, 1'b0,   3,   1};

    tick();
    tick();
    check("reset busy", busy, 0);
    check("reset sign_out", sign_out, 0);
    check("reset period_out", period_out, 0);
    rst = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset in the middle of DIVP aborts the request without committing anything.
    v = '{1_000_000, 50, 0, 1'b0, 100, 50};
    sb.push_back('{100, 50, 75});
    freq_set = 28'd1_000_000;
    duty_set = 7'd50;
    load     = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("pre-reset busy", busy, 1);
    rst = 1'b0;
    #1;
    check("async busy", busy, 0);
    check("async sign_out", sign_out, 0);
    check("async period_out", period_out, 0);
    sb.delete();
    tick();
    tick();
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (busy !== 1'b0 || sign_out !== 1'b0 || period_out !== 32'd0) bad++;
    end
    check("post-reset stopped errs", bad, 0);
    cur_p = 0;
    cur_h = 0;
    run_vec(v, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
